// File: rtl/cpu_log_extractor.sv
// -----------------------------------------------------------------------------
// cpu_log_extractor
//
// Parses the CPU-trace character stream into binary write records. It accepts
// two line forms (hex digits are lowercase only):
//   register write : ^<time>@<pc>: $<grf> <= <data>#
//   memory write   : ^<time>@<pc>: *<addr> <= <data>#
// Each completed record goes into a 2-entry FIFO, which is drained through a
// valid/ready handshake. A record that arrives while the FIFO is full, with no
// pop in the same cycle, is discarded and counted in a saturating counter.
//
// Optional build macro:
//   CPU_LOG_GRF0_FILTER_EN - if defined, completed register-write records that
//                            target grf 0 are silently discarded. They are not
//                            pushed and not counted.
//
// Parameters:
//   DROP_W     width of the saturating drop counter
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   char       in   8       ASCII character, one sampled every cycle
//   rec_valid  out  1       FIFO head holds a record
//   rec_ready  in   1       consumer accepts the head this cycle
//   rec_type   out  1       0 = register write, 1 = memory write
//   rec_time   out  14      decimal time field, binary
//   rec_pc     out  32      hex PC field
//   rec_dest   out  32      grf number (zero-extended) or memory address
//   rec_data   out  32      hex data field
//   drop_cnt   out  DROP_W  records discarded because the FIFO was full
// -----------------------------------------------------------------------------
module cpu_log_extractor #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic              rec_type,
    output logic [13:0]       rec_time,
    output logic [31:0]       rec_pc,
    output logic [31:0]       rec_dest,
    output logic [31:0]       rec_data,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_TIME,
        S_PC,
        S_COLON,
        S_SP1,
        S_GRF,
        S_ADDR,
        S_SP2,
        S_EQ,
        S_SP3,
        S_DATA,
        S_END
    } state_t;

    typedef struct packed {
        logic        f_type;
        logic [13:0] f_time;
        logic [31:0] f_pc;
        logic [31:0] f_dest;
        logic [31:0] f_data;
    } rec_t;

    localparam logic [7:0] C_CARET  = 8'h5E;  // ^
    localparam logic [7:0] C_AT     = 8'h40;  // @
    localparam logic [7:0] C_COLON  = 8'h3A;  // :
    localparam logic [7:0] C_SP     = 8'h20;  // space
    localparam logic [7:0] C_DOLLAR = 8'h24;  // $
    localparam logic [7:0] C_STAR   = 8'h2A;  // *
    localparam logic [7:0] C_LT     = 8'h3C;  // <
    localparam logic [7:0] C_EQ     = 8'h3D;  // =
    localparam logic [7:0] C_HASH   = 8'h23;  // #

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    logic       w_is_dec;
    logic       w_is_hex;
    logic [3:0] w_nibble;

    assign w_is_dec = (char >= 8'h30) && (char <= 8'h39);
    assign w_is_hex = w_is_dec || ((char >= 8'h61) && (char <= 8'h66));
    // The low nibble of '0'..'9' is the digit itself. For 'a'..'f' it is 1..6,
    // so adding 9 gives 10..15.
    assign w_nibble = w_is_dec ? char[3:0] : (char[3:0] + 4'd9);

    // ------------------------------------------------------------------
    // Parser state and field accumulators
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_type;
    logic [13:0] r_time;
    logic [31:0] r_pc;
    logic [31:0] r_dest;
    logic [31:0] r_data;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_type_nxt;
    logic [13:0] w_time_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_dest_nxt;
    logic [31:0] w_data_nxt;
    logic        w_complete;
    logic        w_err;

    // The decimal fields are kept at 14 bits. 9999 is the largest value that
    // four digits can form, and it fits.
    logic [13:0] w_time_dec;
    logic [13:0] w_grf_dec;

    assign w_time_dec = r_time * 14'd10 + {10'd0, char[3:0]};
    assign w_grf_dec  = r_dest[13:0] * 14'd10 + {10'd0, char[3:0]};

    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that does not assign a signal then keeps the default, and no latch
        // is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_type_nxt  = r_type;
        w_time_nxt  = r_time;
        w_pc_nxt    = r_pc;
        w_dest_nxt  = r_dest;
        w_data_nxt  = r_data;
        w_complete  = 1'b0;
        w_err       = 1'b0;

        if (char == C_CARET) begin
            // A caret always starts a new line, whatever state the parser is in.
            w_state_nxt = S_TIME;
            w_cnt_nxt   = '0;
            w_type_nxt  = 1'b0;
            w_time_nxt  = '0;
            w_pc_nxt    = '0;
            w_dest_nxt  = '0;
            w_data_nxt  = '0;
        end else begin
            unique case (r_state)
                S_IDLE: ;
                S_TIME: begin
                    if (w_is_dec && (r_cnt < 4'd4)) begin
                        w_time_nxt = w_time_dec;
                        w_cnt_nxt  = r_cnt + 4'd1;
                    end else if ((char == C_AT) && (r_cnt != 4'd0)) begin
                        w_state_nxt = S_PC;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_PC: begin
                    if (w_is_hex) begin
                        w_pc_nxt = {r_pc[27:0], w_nibble};
                        if (r_cnt == 4'd7) begin
                            w_state_nxt = S_COLON;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_COLON: begin
                    if (char == C_COLON) w_state_nxt = S_SP1;
                    else                 w_err = 1'b1;
                end
                S_SP1: begin
                    if (char == C_DOLLAR) begin
                        w_state_nxt = S_GRF;
                        w_type_nxt  = 1'b0;
                    end else if (char == C_STAR) begin
                        w_state_nxt = S_ADDR;
                        w_type_nxt  = 1'b1;
                    end else if (char != C_SP) begin
                        w_err = 1'b1;
                    end
                end
                S_GRF: begin
                    if (w_is_dec && (r_cnt < 4'd4)) begin
                        w_dest_nxt = {18'd0, w_grf_dec};
                        w_cnt_nxt  = r_cnt + 4'd1;
                    end else if ((char == C_SP) && (r_cnt != 4'd0)) begin
                        w_state_nxt = S_SP2;
                    end else if ((char == C_LT) && (r_cnt != 4'd0)) begin
                        w_state_nxt = S_EQ;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_ADDR: begin
                    if (w_is_hex) begin
                        w_dest_nxt = {r_dest[27:0], w_nibble};
                        if (r_cnt == 4'd7) begin
                            w_state_nxt = S_SP2;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_SP2: begin
                    if (char == C_LT)      w_state_nxt = S_EQ;
                    else if (char != C_SP) w_err = 1'b1;
                end
                S_EQ: begin
                    if (char == C_EQ) begin
                        w_state_nxt = S_SP3;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_SP3: begin
                    if (w_is_hex) begin
                        // The first data digit leaves SP3, so the count starts at 1.
                        w_state_nxt = S_DATA;
                        w_data_nxt  = {r_data[27:0], w_nibble};
                        w_cnt_nxt   = 4'd1;
                    end else if (char != C_SP) begin
                        w_err = 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_is_hex) begin
                        w_data_nxt = {r_data[27:0], w_nibble};
                        if (r_cnt == 4'd7) begin
                            w_state_nxt = S_END;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_END: begin
                    if (char == C_HASH) w_complete = 1'b1;
                    else                w_err = 1'b1;
                end
                default: w_err = 1'b1;
            endcase
        end

        // An error and a completed line both return the parser to IDLE with
        // cleared fields. The record itself is taken from the registers, which
        // are still intact this cycle.
        if (w_err || w_complete) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_type_nxt  = 1'b0;
            w_time_nxt  = '0;
            w_pc_nxt    = '0;
            w_dest_nxt  = '0;
            w_data_nxt  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments. All flops then
    // update together at the edge, no matter what order the statements are in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_type <= 1'b0;
            r_time <= '0;
            r_pc   <= '0;
            r_dest <= '0;
            r_data <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_type <= w_type_nxt;
            r_time <= w_time_nxt;
            r_pc   <= w_pc_nxt;
            r_dest <= w_dest_nxt;
            r_data <= w_data_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Record push decision
    // ------------------------------------------------------------------
    rec_t w_new;
    logic w_push_req;

    assign w_new = '{f_type: r_type, f_time: r_time, f_pc: r_pc,
                     f_dest: r_dest, f_data: r_data};

`ifdef CPU_LOG_GRF0_FILTER_EN
    assign w_push_req = w_complete && !((r_type == 1'b0) && (r_dest == 32'd0));
`else
    assign w_push_req = w_complete;
`endif

    // ------------------------------------------------------------------
    // 2-entry FIFO: r_head drives the outputs, and r_tail is the second slot.
    // ------------------------------------------------------------------
    rec_t              r_head;
    rec_t              r_tail;
    logic              r_head_vld;
    logic              r_tail_vld;
    logic [DROP_W-1:0] r_drop;

    logic w_pop;
    logic w_accept;
    logic w_drop;

    assign w_pop    = r_head_vld && rec_ready;
    // The FIFO is full only when the tail is occupied. A pop in the same
    // cycle frees a slot, so the new record is still accepted.
    assign w_accept = w_push_req && (!r_tail_vld || w_pop);
    assign w_drop   = w_push_req && !w_accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the storage slots are reset as well as the valid bits,
            // because the record outputs must read zero after reset.
            r_head     <= '0;
            r_tail     <= '0;
            r_head_vld <= 1'b0;
            r_tail_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_vld) begin
                r_head <= r_tail;
                if (w_accept) r_tail <= w_new;
                else          r_tail_vld <= 1'b0;
            end else begin
                if (w_accept) r_head <= w_new;
                else          r_head_vld <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_head_vld) begin
                r_head     <= w_new;
                r_head_vld <= 1'b1;
            end else begin
                r_tail     <= w_new;
                r_tail_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
            r_drop <= r_drop + {{(DROP_W-1){1'b0}}, 1'b1};
        end
    end

    assign rec_valid = r_head_vld;
    assign rec_type  = r_head.f_type;
    assign rec_time  = r_head.f_time;
    assign rec_pc    = r_head.f_pc;
    assign rec_dest  = r_head.f_dest;
    assign rec_data  = r_head.f_data;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_cpu_log_extractor.sv
// -----------------------------------------------------------------------------
// tb_cpu_log_extractor
//
// Self-checking bench for cpu_log_extractor. The stimulus process drives trace
// lines and pushes the record each line should produce into a queue. A monitor
// on the falling clock edge compares the DUT head against the front of the
// queue whenever rec_valid is high, and pops the queue on every handshake.
// -----------------------------------------------------------------------------
module tb_cpu_log_extractor;

    typedef struct packed {
        logic        f_type;
        logic [13:0] f_time;
        logic [31:0] f_pc;
        logic [31:0] f_dest;
        logic [31:0] f_data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  char;
    logic        rec_valid;
    logic        rec_ready;
    logic        rec_type;
    logic [13:0] rec_time;
    logic [31:0] rec_pc;
    logic [31:0] rec_dest;
    logic [31:0] rec_data;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    cpu_log_extractor #(.DROP_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .char      (char),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_type  (rec_type),
        .rec_time  (rec_time),
        .rec_pc    (rec_pc),
        .rec_dest  (rec_dest),
        .rec_data  (rec_data),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rec(input logic t, input logic [13:0] tm,
                              input logic [31:0] pc, input logic [31:0] dst,
                              input logic [31:0] dat);
        exp_t e;
        e = '{f_type: t, f_time: tm, f_pc: pc, f_dest: dst, f_data: dat};
        exp_q.push_back(e);
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk);
            #1 char = s[i];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 char = 8'h00;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && rec_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_record: got type=%0d time=%0d pc=%h dest=%h data=%h, required none",
                         rec_type, rec_time, rec_pc, rec_dest, rec_data);
            end else begin
                check("record", {17'd0, rec_type, rec_time, rec_pc, rec_dest, rec_data},
                      {17'd0, exp_q[0]});
                if (rec_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b0;
        char      = 8'h00;
        rec_ready = 1'b1;
        idle(2);
        check("reset_valid", {127'd0, rec_valid}, 128'd0);
        check("reset_fields", {17'd0, rec_type, rec_time, rec_pc, rec_dest, rec_data}, 128'd0);
        check("reset_drop", {120'd0, drop_cnt}, 128'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(2);

        // Basic register write
        expect_rec(1'b0, 14'd12, 32'h0000_3000, 32'd3, 32'h0000_abcd);
        send_line("^12@00003000: $3 <= 0000abcd#");
        idle(4);

        // Memory write, maximum time, extra spaces
        expect_rec(1'b1, 14'd9999, 32'h0000_300c, 32'h0000_1004, 32'hffff_ffff);
        send_line("^9999@0000300c:  *00001004   <=  ffffffff#");
        idle(4);

        // Bad hex digit drops the line. The next line is compact, with no spaces.
        expect_rec(1'b0, 14'd6, 32'h0000_3004, 32'd1, 32'h0000_0001);
        send_line("^5@00003000: $31 <= 0000000G#");
        send_line("^6@00003004: $1<=00000001#");
        idle(4);
        check("drop_after_bad", {120'd0, drop_cnt}, 128'd0);

        // grf 0 register write
`ifndef CPU_LOG_GRF0_FILTER_EN
        expect_rec(1'b0, 14'd1, 32'h0000_3000, 32'd0, 32'h0000_0005);
`endif
        send_line("^1@00003000: $0 <= 00000005#");
        idle(4);
        check("drop_after_grf0", {120'd0, drop_cnt}, 128'd0);

        // Backpressure: the third line is dropped.
        @(posedge clk);
        #1 rec_ready = 1'b0;
        expect_rec(1'b0, 14'd100, 32'h0000_4000, 32'd7, 32'h0000_0007);
        expect_rec(1'b1, 14'd101, 32'h0000_4004, 32'h0000_200c, 32'h1234_5678);
        send_line("^100@00004000: $7 <= 00000007#");
        send_line("^101@00004004: *0000200c <= 12345678#");
        send_line("^102@00004008: $8 <= 00000008#");
        idle(3);
        check("bp_valid", {127'd0, rec_valid}, 128'd1);
        check("bp_drop", {120'd0, drop_cnt}, 128'd1);
        check("bp_queued", exp_q.size(), 128'd2);
        @(posedge clk);
        #1 rec_ready = 1'b1;
        idle(5);
        check("bp_drained", exp_q.size(), 128'd0);

        // Caret mid-line restarts the parse.
        expect_rec(1'b0, 14'd2, 32'h0000_3000, 32'd4, 32'h0000_0002);
        send_line("^1@0000");
        send_line("^2@00003000: $4 <= 00000002#");
        idle(4);

        // Reset pulsed mid-line: the partial record is discarded at once.
        send_line("^7@00003000: $4 <= 0000");
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst_valid", {127'd0, rec_valid}, 128'd0);
        check("midrst_fields", {17'd0, rec_type, rec_time, rec_pc, rec_dest, rec_data}, 128'd0);
        check("midrst_drop", {120'd0, drop_cnt}, 128'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        send_line("0002#");
        idle(4);
        check("midrst_no_record", {127'd0, rec_valid}, 128'd0);

        // Bounded wait for any outstanding expectations.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_empty", exp_q.size(), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_log_extractor.md
# cpu_log_extractor

- Sits downstream of the CPU-trace character stream, in parallel with the format checker.
- Parses each well-formed trace line into binary fields:
  - register-write lines, `^<time>@<pc>: $<grf> <= <data>#`
  - memory-write lines, `^<time>@<pc>: *<addr> <= <data>#`
- Pushes each completed record into a 2-entry output buffer drained through a valid/ready handshake.
- Counts records lost to backpressure.

## Interface
Parameters:
- DROP_W, 8, width of the saturating drop counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- char  in  8  ASCII character, one sampled every cycle
- rec_valid  out  1  buffer head holds a record
- rec_ready  in  1  consumer accepts head this cycle
- rec_type  out  1  0 = register write, 1 = memory write
- rec_time  out  14  decimal time field, binary
- rec_pc  out  32  hex PC field
- rec_dest  out  32  grf number (zero-extended) or memory address
- rec_data  out  32  hex data field
- drop_cnt  out  DROP_W  records discarded because buffer full

## Operation
Grammar (hex = lowercase 0-9/a-f only):
- `^`, then 1–4 decimal digits, `@`, exactly 8 hex, `:`, 0+ spaces.
- Register write: `$`, 1–4 decimal digits, 0+ spaces, `<=`, 0+ spaces, exactly 8 hex, `#`.
- Memory write: `*`, exactly 8 hex, 0+ spaces, `<=`, 0+ spaces, exactly 8 hex, `#`.

Parser FSM states: IDLE, TIME, PC, COLON, SP1, GRF, ADDR, SP2, EQ, SP3, DATA, END.
- Field digit counter bounds each digit run.
- Any character not allowed in the current state returns the FSM to IDLE, clears accumulators and drops the partial line. It is not counted in drop_cnt.
- `^` in any state restarts: TIME is entered with cleared accumulators.

Field conversion:
- Decimal: acc <= acc*10 + digit, computed at 14 bits. Max 9999 fits.
- Hex: acc <= {acc[27:0], nibble}.
- grf is accumulated in a 14-bit field and zero-extended into rec_dest.

Record completion and buffering:
- `#` in END completes the record and the FSM returns to IDLE.
- Completed record is pushed if the buffer is not full, or if a pop happens in the same cycle.
- Otherwise the record is discarded and drop_cnt increments, saturating at all-ones.
- Buffer is a 2-entry FIFO. Head appears on the rec_* outputs.
- Pop occurs when rec_valid && rec_ready.
- rec_* fields are don't-care while rec_valid = 0, but are held stable while rec_valid = 1 and not popped.

## Timing
- All outputs registered.
- Reset values: rec_valid = 0, rec_type = 0, rec_time = 0, rec_pc = 0, rec_dest = 0, rec_data = 0, drop_cnt = 0.
- Reset also empties the FIFO and sets the FSM to IDLE.
- Reset assertion mid-line discards the partial record immediately, without waiting for a clock edge.
- Latency: `#` sampled at edge N with an empty buffer gives rec_valid = 1 after edge N.
- Simultaneous push and pop:
  - Full: head advances, new record enters the tail, no drop.
  - One entry: output stays valid, showing the new record.
- Consumer may hold rec_ready high permanently. Back-to-back records then each appear for one cycle.

## Configuration
- CPU_LOG_GRF0_FILTER_EN defined:
  - A completed register-write record with grf = 0 is silently discarded.
  - It is neither pushed nor counted in drop_cnt.
  - Memory writes to address 0 are unaffected.
- Undefined: all completed records are handled as above.

## Test plan
- `^12@00003000: $3 <= 0000abcd#` with rec_ready = 1 -> one-cycle rec_valid with type 0, time 12, pc 0x3000, dest 3, data 0xabcd.
- `^9999@0000300c:  *00001004   <=  ffffffff#` -> type 1, time 9999, dest 0x1004, data 0xffffffff.
- `^5@00003000: $31 <= 0000000G#`, then `^6@00003004: $1<=00000001#` -> only the second line produces a record, and drop_cnt stays 0.
- rec_ready = 0, send three valid lines -> rec_valid = 1, head is the first line, drop_cnt = 1. Raise rec_ready -> the first two records drain in order.
- Abort mid-line:
  - `^1@0000` then `^2@00003000: $4 <= 00000002#` -> single record, time 2.
  - Reset pulsed mid-line -> no record, all outputs at reset values.
- `^1@00003000: $0 <= 00000005#` -> record present with the macro undefined; absent with CPU_LOG_GRF0_FILTER_EN defined, and drop_cnt = 0 in both cases.
